// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: round-robin dispense sequencer for coffee/sprite.
// Grants one product at a time, runs its motor, waits for the drop sensor,
// tracks per-product stock and reports empty/fault status.
// Optional build macro: VEND_REFUND_EN adds o_refund (pulse on reject or fault entry).
module vend_dispense_ctrl #(
    parameter int unsigned MOTOR_CYC  = 4,
    parameter int unsigned SENSE_TMO  = 16,
    parameter int unsigned COOL_CYC   = 2,
    parameter int unsigned STOCK_INIT = 3,
    parameter int unsigned STOCK_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req_coffee,
    input  logic i_req_sprite,
    input  logic i_drop_sense,
    input  logic i_restock,
    input  logic i_fault_clr,
    output logic o_motor_coffee,
    output logic o_motor_sprite,
    output logic o_busy,
    output logic o_done,
    output logic o_fault,
    output logic o_empty_coffee,
    output logic o_empty_sprite
`ifdef VEND_REFUND_EN
    ,
    output logic o_refund
`endif
);

    localparam int unsigned CNT_W = $clog2(MOTOR_CYC + SENSE_TMO + COOL_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOTOR,
        S_SENSE,
        S_COOL,
        S_FAULT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pend_c_q, pend_c_d;
    logic               pend_s_q, pend_s_d;
    logic               last_s_q, last_s_d;   // 1: sprite was granted last
    logic               motor_c_q, motor_c_d;
    logic               motor_s_q, motor_s_d;
    logic               done_q, done_d;
    logic [STOCK_W-1:0] stock_c_q, stock_c_d;
    logic [STOCK_W-1:0] stock_s_q, stock_s_d;
`ifdef VEND_REFUND_EN
    logic               refund_q, refund_d;
`endif

    logic req_c_v, req_s_v, elig_c, elig_s;

    // A request counts in IDLE if latched earlier or arriving this cycle; stock gates eligibility
    assign req_c_v = pend_c_q | i_req_coffee;
    assign req_s_v = pend_s_q | i_req_sprite;
    assign elig_c  = req_c_v && (stock_c_q != '0);
    assign elig_s  = req_s_v && (stock_s_q != '0);

    // Next-state, pending, motor, stock and pulse logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_c_d  = pend_c_q | (i_req_coffee && (state_q != S_FAULT));
        pend_s_d  = pend_s_q | (i_req_sprite && (state_q != S_FAULT));
        last_s_d  = last_s_q;
        motor_c_d = motor_c_q;
        motor_s_d = motor_s_q;
        done_d    = 1'b0;
        stock_c_d = stock_c_q;
        stock_s_d = stock_s_q;
`ifdef VEND_REFUND_EN
        refund_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_c_v && (stock_c_q == '0)) begin
                    pend_c_d = 1'b0;
`ifdef VEND_REFUND_EN
                    refund_d = 1'b1;
`endif
                end
                if (req_s_v && (stock_s_q == '0)) begin
                    pend_s_d = 1'b0;
`ifdef VEND_REFUND_EN
                    refund_d = 1'b1;
`endif
                end
                if (elig_c && (!elig_s || last_s_q)) begin
                    pend_c_d  = 1'b0;
                    last_s_d  = 1'b0;
                    motor_c_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_MOTOR;
                end else if (elig_s) begin
                    pend_s_d  = 1'b0;
                    last_s_d  = 1'b1;
                    motor_s_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_MOTOR;
                end
            end
            S_MOTOR: begin
                if (cnt_q == CNT_W'(MOTOR_CYC - 1)) begin
                    motor_c_d = 1'b0;
                    motor_s_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_SENSE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SENSE: begin
                if (i_drop_sense) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_COOL;
                    if (last_s_q) begin
                        stock_s_d = stock_s_q - STOCK_W'(1);
                    end else begin
                        stock_c_d = stock_c_q - STOCK_W'(1);
                    end
                end else if (cnt_q == CNT_W'(SENSE_TMO - 1)) begin
                    pend_c_d = 1'b0;
                    pend_s_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = S_FAULT;
`ifdef VEND_REFUND_EN
                    refund_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_COOL: begin
                if (cnt_q == CNT_W'(COOL_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FAULT: begin
                pend_c_d  = 1'b0;
                pend_s_d  = 1'b0;
                motor_c_d = 1'b0;
                motor_s_d = 1'b0;
                if (i_fault_clr) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                motor_c_d = 1'b0;
                motor_s_d = 1'b0;
            end
        endcase
        // Restock overrides any same-cycle decrement
        if (i_restock) begin
            stock_c_d = STOCK_W'(STOCK_INIT);
            stock_s_d = STOCK_W'(STOCK_INIT);
        end
    end

    // State and datapath registers; reset drops motors immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pend_c_q  <= 1'b0;
            pend_s_q  <= 1'b0;
            last_s_q  <= 1'b1;
            motor_c_q <= 1'b0;
            motor_s_q <= 1'b0;
            done_q    <= 1'b0;
            stock_c_q <= STOCK_W'(STOCK_INIT);
            stock_s_q <= STOCK_W'(STOCK_INIT);
`ifdef VEND_REFUND_EN
            refund_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_c_q  <= pend_c_d;
            pend_s_q  <= pend_s_d;
            last_s_q  <= last_s_d;
            motor_c_q <= motor_c_d;
            motor_s_q <= motor_s_d;
            done_q    <= done_d;
            stock_c_q <= stock_c_d;
            stock_s_q <= stock_s_d;
`ifdef VEND_REFUND_EN
            refund_q  <= refund_d;
`endif
        end
    end

    assign o_motor_coffee = motor_c_q;
    assign o_motor_sprite = motor_s_q;
    assign o_done         = done_q;
    assign o_busy         = (state_q != S_IDLE);
    assign o_fault        = (state_q == S_FAULT);
    assign o_empty_coffee = (stock_c_q == '0);
    assign o_empty_sprite = (stock_s_q == '0);
`ifdef VEND_REFUND_EN
    assign o_refund       = refund_q;
`endif

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Testbench for vend_dispense_ctrl: expected grant order is queued when requests
// are driven and popped when a motor starts; status is checked against a stock model.
`timescale 1ns/1ps
module tb_vend_dispense_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_c = 1'b0, req_s = 1'b0, drop = 1'b0, restock = 1'b0, fclr = 1'b0;
    logic mc, ms, busy, done, fault, ec, es;
`ifdef VEND_REFUND_EN
    logic refund;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_q[$];            // expected grant order: 0 coffee, 1 sprite
    int stock_c  = 3;
    int stock_s  = 3;
    int last     = 1;        // model of last granted product

    always #5 clk = ~clk;

    vend_dispense_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_coffee   (req_c),
        .i_req_sprite   (req_s),
        .i_drop_sense   (drop),
        .i_restock      (restock),
        .i_fault_clr    (fclr),
        .o_motor_coffee (mc),
        .o_motor_sprite (ms),
        .o_busy         (busy),
        .o_done         (done),
        .o_fault        (fault),
        .o_empty_coffee (ec),
        .o_empty_sprite (es)
`ifdef VEND_REFUND_EN
        ,
        .o_refund       (refund)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Motor monitor: grant order, one-hot, pulse length
    logic prev_c = 1'b0, prev_s = 1'b0;
    int   run = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            run    = 0;
            prev_c = 1'b0;
            prev_s = 1'b0;
        end else begin
            if (mc || ms) check_eq("motor_onehot", 32'(mc & ms), 0);
            if ((mc && !prev_c) || (ms && !prev_s)) begin
                check_eq("grant_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check_eq("grant_product", 32'(ms), 32'(exp_q.pop_front()));
                run = 0;
            end
            if (mc || ms) run++;
            else if (prev_c || prev_s) check_eq("motor_len", 32'(run), 4);
            prev_c = mc;
            prev_s = ms;
        end
    end

    task automatic push_one(input int p);
        exp_q.push_back(p);
        last = p;
    endtask

    task automatic pulse_req(input logic c, input logic s);
        req_c = c;
        req_s = s;
        @(negedge clk);
        req_c = 1'b0;
        req_s = 1'b0;
    endtask

    // Wait until the motor has run and dropped (first SENSE cycle)
    task automatic wait_sense();
        logic seen;
        logic ok;
        seen = mc | ms;
        ok   = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (seen && !(mc | ms)) ok = 1'b1;
            else if (mc | ms) seen = 1'b1;
        end
        check_eq("reach_sense", 32'(ok), 1);
    endtask

    // Serve one vend: drop sensed in the 2nd SENSE cycle, optional same-cycle restock
    task automatic serve(input int prod, input logic rs);
        wait_sense();
        @(negedge clk);
        drop    = 1'b1;
        restock = rs;
        @(negedge clk);
        drop    = 1'b0;
        restock = 1'b0;
        if (rs) begin
            stock_c = 3;
            stock_s = 3;
        end else if (prod == 0) stock_c--;
        else stock_s--;
        check_eq("done_pulse", 32'(done), 1);
        check_eq("empty_coffee", 32'(ec), 32'(stock_c == 0));
        check_eq("empty_sprite", 32'(es), 32'(stock_s == 0));
        check_eq("busy_cool1", 32'(busy), 1);
        @(negedge clk);
        check_eq("done_single", 32'(done), 0);
        check_eq("busy_cool2", 32'(busy), 1);
        @(negedge clk);
        check_eq("busy_idle", 32'(busy), 0);
    endtask

    task automatic idle_quiet(input string tag, input int n);
        repeat (n) @(negedge clk);
        check_eq(tag, 32'({busy, mc, ms}), 0);
    endtask

    initial begin
        int first;
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_outputs", 32'({mc, ms, busy, done, fault, ec, es}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);

        // Single coffee vend
        push_one(0);
        pulse_req(1'b1, 1'b0);
        serve(0, 1'b0);

        // Tie: opposite of the last grant first, then the other right after COOL
        first = (last == 1) ? 0 : 1;
        push_one(first);
        push_one(1 - first);
        pulse_req(1'b1, 1'b1);
        serve(first, 1'b0);
        serve(1 - first, 1'b0);

        // Fault: no drop sensed
        push_one(0);
        pulse_req(1'b1, 1'b0);
        wait_sense();
        for (int i = 2; i <= 16; i++) begin
            if (i == 3) req_s = 1'b1;
            @(negedge clk);
            req_s = 1'b0;
        end
        check_eq("fault_not_early", 32'(fault), 0);
        @(negedge clk);
        check_eq("fault_set", 32'(fault), 1);
        check_eq("fault_busy", 32'(busy), 1);
        check_eq("fault_motors", 32'({mc, ms}), 0);
`ifdef VEND_REFUND_EN
        check_eq("refund_fault", 32'(refund), 1);
`endif
        pulse_req(1'b0, 1'b1);
`ifdef VEND_REFUND_EN
        check_eq("refund_fault_once", 32'(refund), 0);
`endif
        check_eq("fault_hold", 32'(fault), 1);
        fclr = 1'b1;
        @(negedge clk);
        fclr = 1'b0;
        check_eq("fault_clr", 32'({fault, busy}), 0);
        idle_quiet("fault_pend_cleared", 8);

        // Drain coffee to empty (fault must not have consumed stock)
        push_one(0);
        pulse_req(1'b1, 1'b0);
        serve(0, 1'b0);
        check_eq("coffee_empty", 32'(ec), 1);

        // Request with empty stock is rejected
        pulse_req(1'b1, 1'b0);
        check_eq("reject_no_motor", 32'({busy, mc}), 0);
`ifdef VEND_REFUND_EN
        check_eq("refund_reject", 32'(refund), 1);
        @(negedge clk);
        check_eq("refund_reject_once", 32'(refund), 0);
`endif
        idle_quiet("reject_quiet", 5);

        // Restock in the same cycle as the drop
        push_one(1);
        pulse_req(1'b0, 1'b1);
        serve(1, 1'b1);
        idle_quiet("reject_pend_cleared", 8);

        // Reset during MOTOR
        push_one(0);
        pulse_req(1'b1, 1'b0);
        check_eq("motor_running", 32'(mc), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_motor_drop", 32'({mc, ms, busy}), 0);
        stock_c = 3;
        stock_s = 3;
        last    = 1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_release", 32'({busy, ec, es}), 0);

        // Stock reloaded by reset: three more coffee vends, empty only after the third
        for (int k = 0; k < 3; k++) begin
            push_one(0);
            pulse_req(1'b1, 1'b0);
            serve(0, 1'b0);
        end
        check_eq("reset_stock_empty", 32'(ec), 1);

        check_eq("grants_all_seen", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
